// File: rtl/otter_alu_pkg.sv
// Shared opcode encodings and state types for the OTTER execute-stage ALU/MDU.
package otter_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_fun_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        OP_ALU = 2'd0,
        OP_MUL = 2'd1,
        OP_DIV = 2'd2
    } op_kind_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, with
// divide-by-zero / signed-overflow resolved immediately and signs fixed up on output.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic             signed_op,
    input  logic             rem_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_abs, b_abs, spec_val;

    logic             running, spec_pend, neg_q, neg_r, sel_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, rem, dvs, spec_res;

    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] quo_nx, rem_nx;

    always_comb begin
        a_neg    = signed_op & a[WIDTH-1];
        b_neg    = signed_op & b[WIDTH-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        div_zero = (b == '0);
        ovf      = signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        if (div_zero) spec_val = rem_sel ? a : '1;
        else          spec_val = rem_sel ? '0 : a;
    end

    // Partial remainder stays below the divisor, so W+1 bits hold the shifted trial value.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        quo_nx  = {quo[WIDTH-2:0], ~diff[WIDTH]};
        rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    assign done = spec_pend | (running & (cnt == CW'(WIDTH)));

    always_comb begin
        if (spec_pend)  result = spec_res;
        else if (sel_r) result = neg_r ? -rem : rem;
        else            result = neg_q ? -quo : quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            spec_pend <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            sel_r     <= 1'b0;
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            spec_res  <= '0;
        end else if (flush) begin
            running   <= 1'b0;
            spec_pend <= 1'b0;
        end else if (start) begin
            sel_r     <= rem_sel;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            quo       <= a_abs;
            rem       <= '0;
            dvs       <= b_abs;
            cnt       <= '0;
            spec_res  <= spec_val;
            spec_pend <= div_zero | ovf;
            running   <= ~(div_zero | ovf);
        end else if (done) begin
            running   <= 1'b0;
            spec_pend <= 1'b0;
        end else if (running) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked ALU + RV32M multiply/divide unit; one op in flight, result held
// until the consumer takes it.
module alu_mdu
    import otter_alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter bit ENABLE_MDU  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_fun,
    input  logic             md_en,
    input  logic [2:0]       md_fun,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output alu_state_t       dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.

    localparam int SW = $clog2(WIDTH);

    alu_state_t       state_q, state_d;
    op_kind_t         kind_q, kind_d;
    logic [WIDTH-1:0] result_q, res_d;
    logic             res_ld;

    logic             accept, md_en_eff, is_mul, is_div;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] alu_val;

    logic             mul_fin_valid, div_done;
    logic [WIDTH-1:0] mul_fin, mul_direct, div_result;

    function automatic logic [WIDTH-1:0] mul_calc(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       f);
        logic               sa, sb;
        logic [2*WIDTH-1:0] ea, eb, p;
        sa = (f == MD_MULH) || (f == MD_MULHSU);
        sb = (f == MD_MULH);
        ea = {{WIDTH{sa & a[WIDTH-1]}}, a};
        eb = {{WIDTH{sb & b[WIDTH-1]}}, b};
        p  = ea * eb;
        return (f == MD_MUL) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    endfunction

    assign md_en_eff = ENABLE_MDU && md_en;
    assign is_div    = md_en_eff && md_fun[2];
    assign is_mul    = md_en_eff && !md_fun[2];
    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;

    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign alu_result = result_q;
    assign dbg_state  = state_q;

    assign sh = srcB[SW-1:0];

    always_comb begin
        alu_val = srcA;
        case (alu_fun)
            ALU_ADD:  alu_val = srcA + srcB;
            ALU_SUB:  alu_val = srcA - srcB;
            ALU_OR:   alu_val = srcA | srcB;
            ALU_AND:  alu_val = srcA & srcB;
            ALU_XOR:  alu_val = srcA ^ srcB;
            ALU_SRL:  alu_val = srcA >> sh;
            ALU_SLL:  alu_val = srcA << sh;
            ALU_SRA:  alu_val = WIDTH'($signed(srcA) >>> sh);
            ALU_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            ALU_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            default:  alu_val = srcA;
        endcase
    end

    generate
        if (ENABLE_MDU) begin : g_mdu
            alu_divider #(.WIDTH(WIDTH)) u_div (
                .clk       (CLK),
                .rst_n     (RST_N),
                .flush     (flush),
                .start     (accept && is_div),
                .signed_op (!md_fun[0]),
                .rem_sel   (md_fun[1]),
                .a         (srcA),
                .b         (srcB),
                .done      (div_done),
                .result    (div_result)
            );

            if (MUL_LATENCY == 1) begin : g_mul_comb
                assign mul_direct    = mul_calc(srcA, srcB, md_fun);
                assign mul_fin       = '0;
                assign mul_fin_valid = 1'b0;
            end else begin : g_mul_pipe
                // Stage 0 captures operands; the product then rides MUL_LATENCY-2
                // delay registers before landing in the output register.
                logic [WIDTH-1:0] ma, mb, m_prod;
                logic [2:0]       mf;
                logic             mv;

                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        ma <= '0;
                        mb <= '0;
                        mf <= '0;
                        mv <= 1'b0;
                    end else if (flush) begin
                        mv <= 1'b0;
                    end else begin
                        mv <= accept && is_mul;
                        if (accept && is_mul) begin
                            ma <= srcA;
                            mb <= srcB;
                            mf <= md_fun;
                        end
                    end
                end

                assign m_prod     = mul_calc(ma, mb, mf);
                assign mul_direct = '0;

                if (MUL_LATENCY == 2) begin : g_nodly
                    assign mul_fin       = m_prod;
                    assign mul_fin_valid = mv;
                end else begin : g_dly
                    localparam int DLY = MUL_LATENCY - 2;
                    logic [WIDTH-1:0] dl [DLY];
                    logic             dv [DLY];

                    always_ff @(posedge CLK or negedge RST_N) begin
                        if (!RST_N) begin
                            for (int i = 0; i < DLY; i++) begin
                                dl[i] <= '0;
                                dv[i] <= 1'b0;
                            end
                        end else begin
                            dl[0] <= m_prod;
                            dv[0] <= mv && !flush;
                            for (int i = 1; i < DLY; i++) begin
                                dl[i] <= dl[i-1];
                                dv[i] <= dv[i-1] && !flush;
                            end
                        end
                    end

                    assign mul_fin       = dl[DLY-1];
                    assign mul_fin_valid = dv[DLY-1];
                end
            end
        end else begin : g_no_mdu
            assign div_done      = 1'b0;
            assign div_result    = '0;
            assign mul_direct    = '0;
            assign mul_fin       = '0;
            assign mul_fin_valid = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        res_ld  = 1'b0;
        res_d   = result_q;

        if ((state_q == DONE) && out_ready) state_d = IDLE;

        if (state_q == EXEC) begin
            if ((kind_q == OP_MUL) && mul_fin_valid) begin
                state_d = DONE;
                res_ld  = 1'b1;
                res_d   = mul_fin;
            end else if ((kind_q == OP_DIV) && div_done) begin
                state_d = DONE;
                res_ld  = 1'b1;
                res_d   = div_result;
            end
        end

        // A new accept overrides the DONE->IDLE release, giving zero-bubble issue.
        if (accept) begin
            if (is_div) begin
                state_d = EXEC;
                kind_d  = OP_DIV;
            end else if (is_mul) begin
                kind_d = OP_MUL;
                if (MUL_LATENCY == 1) begin
                    state_d = DONE;
                    res_ld  = 1'b1;
                    res_d   = mul_direct;
                end else begin
                    state_d = EXEC;
                end
            end else begin
                state_d = DONE;
                kind_d  = OP_ALU;
                res_ld  = 1'b1;
                res_d   = alu_val;
            end
        end

        if (flush) begin
            state_d = IDLE;
            res_ld  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            kind_q   <= OP_ALU;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            if (res_ld) result_q <= res_d;
        end
    end

endmodule
